// File: rtl/decode_stage_hs.sv
// Handshaked MIPS decode stage: fetch-to-decode and decode-to-execute latches,
// priority operand bypass with load-use interlock, and optional branch resolution.
module decode_stage_hs #(
   parameter int NUM_FWD  = 3,
   parameter bit BR_IN_DE = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fe_valid,
   input  logic [31:0]           fe_inst,
   input  logic [31:0]           fe_pc,
   output logic                  de_allowin,
   input  logic                  flush,
   output logic [4:0]            raddr1,
   output logic [4:0]            raddr2,
   input  logic [31:0]           rdata1,
   input  logic [31:0]           rdata2,
   input  logic [NUM_FWD-1:0]    fwd_valid,
   input  logic [NUM_FWD-1:0]    fwd_wen,
   input  logic [NUM_FWD-1:0]    fwd_is_load,
   input  logic [5*NUM_FWD-1:0]  fwd_dest,
   input  logic [32*NUM_FWD-1:0] fwd_data,
   output logic                  br_taken,
   output logic [31:0]           br_target,
   input  logic                  ex_allowin,
   output logic                  de_to_ex_valid,
   output logic [31:0]           de_pc,
   output logic [31:0]           de_alusrc1,
   output logic [31:0]           de_alusrc2,
   output logic [31:0]           de_rt_data,
   output logic [3:0]            de_aluop,
   output logic                  de_dramen,
   output logic                  de_wen,
   output logic                  de_is_load,
   output logic [3:0]            de_dramwen,
   output logic [4:0]            de_regdst
);

   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                          OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                          OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                          OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                          F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_ADD = 6'h20,
                          F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                          F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A,
                          F_SLTU = 6'h2B;

   typedef enum logic [1:0] {S1_RS, S1_SA, S1_PC} src1_e;
   typedef enum logic [2:0] {S2_ZERO, S2_ZIMM, S2_SIMM, S2_RT, S2_EIGHT} src2_e;

   function automatic logic signed [31:0] sext16(input logic [15:0] v);
      return signed'({{16{v[15]}}, v});
   endfunction

   logic        ds_vld_p0;
   logic [31:0] ds_inst_p0;
   logic [31:0] ds_pc_p0;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm;

   assign op    = ds_inst_p0[31:26];
   assign rs    = ds_inst_p0[25:21];
   assign rt    = ds_inst_p0[20:16];
   assign rd    = ds_inst_p0[15:11];
   assign sa    = ds_inst_p0[10:6];
   assign funct = ds_inst_p0[5:0];
   assign imm   = ds_inst_p0[15:0];

   assign raddr1 = rs;
   assign raddr2 = rt;

   logic [3:0] aluop_d, dramwen_d;
   logic       wen_d, dramen_d, is_load_d;
   logic [4:0] regdst_d;
   src1_e      s1_sel;
   src2_e      s2_sel;
   logic       rs_used, rt_used, is_beq, is_bne, is_j, is_jal, is_jr;

   always_comb begin
      aluop_d   = 4'd0;
      dramwen_d = 4'h0;
      wen_d     = 1'b0;
      dramen_d  = 1'b0;
      is_load_d = 1'b0;
      regdst_d  = 5'd0;
      s1_sel    = S1_RS;
      s2_sel    = S2_ZERO;
      rs_used   = 1'b1;
      rt_used   = 1'b0;
      is_beq    = 1'b0;
      is_bne    = 1'b0;
      is_j      = 1'b0;
      is_jal    = 1'b0;
      is_jr     = 1'b0;
      case (op)
         OP_SPECIAL: begin
            rt_used  = 1'b1;
            s2_sel   = S2_RT;
            wen_d    = 1'b1;
            regdst_d = rd;
            case (funct)
               F_SLL:          begin aluop_d = 4'd6; s1_sel = S1_SA; rs_used = 1'b0; end
               F_SRL:          begin aluop_d = 4'd7; s1_sel = S1_SA; rs_used = 1'b0; end
               F_SRA:          begin aluop_d = 4'd9; s1_sel = S1_SA; rs_used = 1'b0; end
               F_SLLV:         aluop_d = 4'd6;
               F_SRLV:         aluop_d = 4'd7;
               F_SRAV:         aluop_d = 4'd9;
               F_ADD, F_ADDU:  aluop_d = 4'd2;
               F_SUB, F_SUBU:  aluop_d = 4'd3;
               F_AND:          aluop_d = 4'd0;
               F_OR:           aluop_d = 4'd1;
               F_XOR:          aluop_d = 4'd11;
               F_NOR:          aluop_d = 4'd12;
               F_SLT:          aluop_d = 4'd4;
               F_SLTU:         aluop_d = 4'd5;
               F_JR:           begin is_jr = 1'b1; wen_d = 1'b0; regdst_d = 5'd0; end
               default:        begin wen_d = 1'b0; regdst_d = 5'd0; end
            endcase
         end
         OP_J:    begin is_j = 1'b1; rs_used = 1'b0; end
         OP_JAL:  begin
            is_jal = 1'b1; rs_used = 1'b0; wen_d = 1'b1; regdst_d = 5'd31;
            s1_sel = S1_PC; s2_sel = S2_EIGHT; aluop_d = 4'd2;
         end
         OP_BEQ:  begin is_beq = 1'b1; rt_used = 1'b1; end
         OP_BNE:  begin is_bne = 1'b1; rt_used = 1'b1; end
         OP_ADDI, OP_ADDIU: begin aluop_d = 4'd2;  s2_sel = S2_SIMM; wen_d = 1'b1; regdst_d = rt; end
         OP_SLTI:  begin aluop_d = 4'd4;  s2_sel = S2_SIMM; wen_d = 1'b1; regdst_d = rt; end
         OP_SLTIU: begin aluop_d = 4'd5;  s2_sel = S2_SIMM; wen_d = 1'b1; regdst_d = rt; end
         OP_ANDI:  begin aluop_d = 4'd0;  s2_sel = S2_ZIMM; wen_d = 1'b1; regdst_d = rt; end
         OP_ORI:   begin aluop_d = 4'd1;  s2_sel = S2_ZIMM; wen_d = 1'b1; regdst_d = rt; end
         OP_XORI:  begin aluop_d = 4'd11; s2_sel = S2_ZIMM; wen_d = 1'b1; regdst_d = rt; end
         OP_LUI:   begin aluop_d = 4'd10; s2_sel = S2_SIMM; wen_d = 1'b1; regdst_d = rt; end
         OP_LW: begin
            aluop_d = 4'd2; s2_sel = S2_SIMM; wen_d = 1'b1; regdst_d = rt;
            dramen_d = 1'b1; is_load_d = 1'b1;
         end
         OP_SW: begin
            aluop_d = 4'd2; s2_sel = S2_SIMM; rt_used = 1'b1;
            dramen_d = 1'b1; dramwen_d = 4'hF;
         end
         default: ;
      endcase
   end

   // Bypass: scan from oldest to youngest so the lowest index overrides.
   logic [31:0] rs_val, rt_val;
   logic        rs_load, rt_load;

   always_comb begin
      rs_val  = (rs == 5'd0) ? 32'd0 : rdata1;
      rt_val  = (rt == 5'd0) ? 32'd0 : rdata2;
      rs_load = 1'b0;
      rt_load = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_valid[i] && fwd_wen[i] && fwd_dest[5*i +: 5] != 5'd0) begin
            if (fwd_dest[5*i +: 5] == rs) begin
               rs_val  = fwd_data[32*i +: 32];
               rs_load = fwd_is_load[i];
            end
            if (fwd_dest[5*i +: 5] == rt) begin
               rt_val  = fwd_data[32*i +: 32];
               rt_load = fwd_is_load[i];
            end
         end
      end
   end

   logic ds_ready_go, ds_fire;
   assign ds_ready_go = !((rs_used && rs_load) || (rt_used && rt_load));
   assign ds_fire     = ds_vld_p0 && ds_ready_go && ex_allowin;
   assign de_allowin  = !ds_vld_p0 || (ds_ready_go && ex_allowin);

   logic [31:0] alusrc1_d, alusrc2_d, pc4, br_tgt_d;
   logic        br_hit;

   always_comb begin
      unique case (s1_sel)
         S1_SA:   alusrc1_d = {27'd0, sa};
         S1_PC:   alusrc1_d = ds_pc_p0;
         default: alusrc1_d = rs_val;
      endcase
      unique case (s2_sel)
         S2_ZIMM:  alusrc2_d = {16'd0, imm};
         S2_SIMM:  alusrc2_d = unsigned'(sext16(imm));
         S2_RT:    alusrc2_d = rt_val;
         S2_EIGHT: alusrc2_d = 32'd8;
         default:  alusrc2_d = 32'd0;
      endcase
   end

   always_comb begin
      pc4      = ds_pc_p0 + 32'd4;
      br_hit   = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val) ||
                 is_j || is_jal || is_jr;
      br_tgt_d = pc4 + unsigned'(sext16(imm) <<< 2);
      if (is_j || is_jal) br_tgt_d = {pc4[31:28], ds_inst_p0[25:0], 2'b00};
      else if (is_jr)     br_tgt_d = rs_val;
      br_taken  = 1'b0;
      br_target = 32'd0;
      if (BR_IN_DE) begin
         br_taken  = ds_fire && br_hit;
         br_target = br_tgt_d;
      end
   end

   // Stage boundary: fetch -> decode latch.
   always_ff @(posedge clk) begin
      if (reset || flush)  ds_vld_p0 <= 1'b0;
      else if (de_allowin) ds_vld_p0 <= fe_valid;
      if (!reset && !flush && fe_valid && de_allowin) begin
         ds_inst_p0 <= fe_inst;
         ds_pc_p0   <= fe_pc;
      end
   end

   // Stage boundary: decode -> execute latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         de_to_ex_valid <= 1'b0;
         de_pc          <= 32'd0;
         de_alusrc1     <= 32'd0;
         de_alusrc2     <= 32'd0;
         de_rt_data     <= 32'd0;
         de_aluop       <= 4'd0;
         de_dramen      <= 1'b0;
         de_wen         <= 1'b0;
         de_is_load     <= 1'b0;
         de_dramwen     <= 4'h0;
         de_regdst      <= 5'd0;
      end else if (flush) begin
         de_to_ex_valid <= 1'b0;
      end else if (ex_allowin) begin
         de_to_ex_valid <= ds_vld_p0 && ds_ready_go;
         if (ds_vld_p0 && ds_ready_go) begin
            de_pc      <= ds_pc_p0;
            de_alusrc1 <= alusrc1_d;
            de_alusrc2 <= alusrc2_d;
            de_rt_data <= rt_val;
            de_aluop   <= aluop_d;
            de_dramen  <= dramen_d;
            de_wen     <= wen_d;
            de_is_load <= is_load_d;
            de_dramwen <= dramwen_d;
            de_regdst  <= regdst_d;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: forwarding, interlock, branches, hold and flush.
module tb_decode_stage_hs;

   logic        clk = 1'b0;
   logic        reset, fe_valid, flush, ex_allowin;
   logic [31:0] fe_inst, fe_pc, rdata1, rdata2;
   logic        de_allowin, br_taken, de_to_ex_valid;
   logic [4:0]  raddr1, raddr2, de_regdst;
   logic [2:0]  fwd_valid, fwd_wen, fwd_is_load;
   logic [14:0] fwd_dest;
   logic [95:0] fwd_data;
   logic [31:0] br_target, de_pc, de_alusrc1, de_alusrc2, de_rt_data;
   logic [3:0]  de_aluop, de_dramwen;
   logic        de_dramen, de_wen, de_is_load;

   logic [31:0] rf [32];
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign rdata1 = rf[raddr1];
   assign rdata2 = rf[raddr2];

   decode_stage_hs #(.NUM_FWD(3), .BR_IN_DE(1'b1)) dut (
      .clk(clk), .reset(reset), .fe_valid(fe_valid), .fe_inst(fe_inst), .fe_pc(fe_pc),
      .de_allowin(de_allowin), .flush(flush), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2), .fwd_valid(fwd_valid), .fwd_wen(fwd_wen),
      .fwd_is_load(fwd_is_load), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
      .br_taken(br_taken), .br_target(br_target), .ex_allowin(ex_allowin),
      .de_to_ex_valid(de_to_ex_valid), .de_pc(de_pc), .de_alusrc1(de_alusrc1),
      .de_alusrc2(de_alusrc2), .de_rt_data(de_rt_data), .de_aluop(de_aluop),
      .de_dramen(de_dramen), .de_wen(de_wen), .de_is_load(de_is_load),
      .de_dramwen(de_dramwen), .de_regdst(de_regdst)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t,
                                         input logic [15:0] im);
      return {op, s, t, im};
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] s, t, d, sh, input logic [5:0] fn);
      return {6'h00, s, t, d, sh, fn};
   endfunction

   task automatic set_fwd(input int i, input logic ld, input logic [4:0] dest,
                          input logic [31:0] data);
      fwd_valid[i]        = 1'b1;
      fwd_wen[i]          = 1'b1;
      fwd_is_load[i]      = ld;
      fwd_dest[5*i +: 5]  = dest;
      fwd_data[32*i +: 32] = data;
   endtask

   task automatic clr_fwd();
      fwd_valid = '0; fwd_wen = '0; fwd_is_load = '0; fwd_dest = '0; fwd_data = '0;
   endtask

   task automatic fetch(input logic [31:0] inst, input logic [31:0] pc);
      fe_valid = 1'b1; fe_inst = inst; fe_pc = pc;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
      rf[0] = 32'hDEAD_0000;
      reset = 1'b1; flush = 1'b0; ex_allowin = 1'b1;
      fe_valid = 1'b0; fe_inst = '0; fe_pc = '0;
      clr_fwd();
      tick(); tick();
      chk("rst_valid", {31'd0, de_to_ex_valid}, 32'd0);
      chk("rst_pc", de_pc, 32'd0);
      chk("rst_src1", de_alusrc1, 32'd0);
      chk("rst_brtaken", {31'd0, br_taken}, 32'd0);
      chk("rst_allowin", {31'd0, de_allowin}, 32'd1);
      reset = 1'b0;

      // ADDIU $1,$0,5 then ADDU $2,$1,$1 with $1 bypassed from source 0
      fetch(itype(6'h09, 5'd0, 5'd1, 16'd5), 32'h0);
      tick();
      fetch(rtype(5'd1, 5'd1, 5'd2, 5'd0, 6'h21), 32'h4);
      tick();
      chk("addiu_valid", {31'd0, de_to_ex_valid}, 32'd1);
      chk("addiu_src1_r0", de_alusrc1, 32'd0);
      chk("addiu_src2", de_alusrc2, 32'd5);
      chk("addiu_regdst", {27'd0, de_regdst}, 32'd1);
      fe_valid = 1'b0;
      set_fwd(0, 1'b0, 5'd1, 32'd5);
      tick();
      chk("addu_valid", {31'd0, de_to_ex_valid}, 32'd1);
      chk("addu_src1", de_alusrc1, 32'd5);
      chk("addu_src2", de_alusrc2, 32'd5);
      chk("addu_regdst", {27'd0, de_regdst}, 32'd2);
      chk("addu_aluop", {28'd0, de_aluop}, 32'd2);
      chk("addu_wen", {31'd0, de_wen}, 32'd1);
      chk("addu_pc", de_pc, 32'h4);
      clr_fwd();
      tick();
      chk("drain_valid", {31'd0, de_to_ex_valid}, 32'd0);

      // LW $3,0($7) then ADDU $4,$3,$0: one bubble, then MEM-stage bypass
      fetch(itype(6'h23, 5'd7, 5'd3, 16'd0), 32'h20);
      tick();
      fetch(rtype(5'd3, 5'd0, 5'd4, 5'd0, 6'h21), 32'h24);
      tick();
      chk("lw_isload", {31'd0, de_is_load}, 32'd1);
      chk("lw_dramen", {31'd0, de_dramen}, 32'd1);
      chk("lw_src1", de_alusrc1, 32'h1007);
      chk("lw_regdst", {27'd0, de_regdst}, 32'd3);
      fe_valid = 1'b0;
      set_fwd(0, 1'b1, 5'd3, 32'hBAD0_0000);
      #1;
      chk("lu_allowin_stall", {31'd0, de_allowin}, 32'd0);
      tick();
      chk("lu_bubble", {31'd0, de_to_ex_valid}, 32'd0);
      clr_fwd();
      set_fwd(1, 1'b0, 5'd3, 32'hCAFE_0003);
      #1;
      chk("lu_allowin_rel", {31'd0, de_allowin}, 32'd1);
      tick();
      chk("lu_valid", {31'd0, de_to_ex_valid}, 32'd1);
      chk("lu_src1", de_alusrc1, 32'hCAFE_0003);
      chk("lu_src2_r0", de_alusrc2, 32'd0);
      chk("lu_pc", de_pc, 32'h24);
      clr_fwd();

      // BEQ $5,$6,+4 at 0x100, equal then unequal; BNE backwards
      rf[5] = 32'h77; rf[6] = 32'h77;
      fetch(itype(6'h04, 5'd5, 5'd6, 16'd4), 32'h100);
      tick();
      fe_valid = 1'b0;
      chk("beq_taken", {31'd0, br_taken}, 32'd1);
      chk("beq_target", br_target, 32'h114);
      tick();
      chk("beq_pulse", {31'd0, br_taken}, 32'd0);
      chk("beq_wen", {31'd0, de_wen}, 32'd0);
      rf[6] = 32'h78;
      fetch(itype(6'h04, 5'd5, 5'd6, 16'd4), 32'h200);
      tick();
      fe_valid = 1'b0;
      chk("beq_ne_taken", {31'd0, br_taken}, 32'd0);
      fetch(itype(6'h05, 5'd5, 5'd6, 16'hFFFF), 32'h300);
      tick();
      fe_valid = 1'b0;
      chk("bne_taken", {31'd0, br_taken}, 32'd1);
      chk("bne_target", br_target, 32'h300);

      // JAL 0x40 at 0x10000000
      fetch({6'h03, 26'h40}, 32'h1000_0000);
      tick();
      fe_valid = 1'b0;
      chk("jal_taken", {31'd0, br_taken}, 32'd1);
      chk("jal_target", br_target, 32'h1000_0100);
      tick();
      chk("jal_src1", de_alusrc1, 32'h1000_0000);
      chk("jal_src2", de_alusrc2, 32'd8);
      chk("jal_regdst", {27'd0, de_regdst}, 32'd31);
      chk("jal_wen", {31'd0, de_wen}, 32'd1);

      // ORI then J, execute stalls 3 cycles, then flush during hold
      fetch(itype(6'h0D, 5'd9, 5'd8, 16'h8000), 32'h400);
      tick();
      fetch({6'h02, 26'h123}, 32'h404);
      tick();
      fetch(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h408);
      ex_allowin = 1'b0;
      #1;
      chk("hold_allowin", {31'd0, de_allowin}, 32'd0);
      chk("hold_brtaken", {31'd0, br_taken}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("hold_valid", {31'd0, de_to_ex_valid}, 32'd1);
         chk("hold_pc", de_pc, 32'h400);
         chk("hold_src2_zimm", de_alusrc2, 32'h0000_8000);
         chk("hold_src1", de_alusrc1, 32'h1009);
         chk("hold_brtaken_c", {31'd0, br_taken}, 32'd0);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      fe_valid = 1'b0;
      #1;
      chk("flush_valid", {31'd0, de_to_ex_valid}, 32'd0);
      chk("flush_ds_empty", {31'd0, de_allowin}, 32'd1);
      ex_allowin = 1'b1;
      tick();
      chk("flush_no_emit", {31'd0, de_to_ex_valid}, 32'd0);

      // Priority: same dest in source 0 and 2; source 1 not writing
      fetch(rtype(5'd14, 5'd0, 5'd13, 5'd0, 6'h21), 32'h500);
      tick();
      fe_valid = 1'b0;
      set_fwd(2, 1'b0, 5'd14, 32'h0000_CCCC);
      set_fwd(1, 1'b0, 5'd14, 32'h0000_BBBB);
      fwd_wen[1] = 1'b0;
      set_fwd(0, 1'b0, 5'd14, 32'h0000_AAAA);
      tick();
      chk("prio_src1", de_alusrc1, 32'h0000_AAAA);
      clr_fwd();

      // Destination 0 never bypasses; register 0 reads zero
      fetch(rtype(5'd0, 5'd0, 5'd15, 5'd0, 6'h21), 32'h600);
      tick();
      fe_valid = 1'b0;
      set_fwd(0, 1'b0, 5'd0, 32'h0000_1234);
      tick();
      chk("r0_src1", de_alusrc1, 32'd0);
      clr_fwd();

      // SLL $16,$17,5 uses shamt as operand 1
      fetch(rtype(5'd0, 5'd17, 5'd16, 5'd5, 6'h00), 32'h700);
      tick();
      fe_valid = 1'b0;
      tick();
      chk("sll_src1", de_alusrc1, 32'd5);
      chk("sll_src2", de_alusrc2, 32'h1011);
      chk("sll_aluop", {28'd0, de_aluop}, 32'd6);

      // Unknown opcode decodes as NOP
      fetch({6'h3F, 26'h3FF_FFFF}, 32'h800);
      tick();
      fe_valid = 1'b0;
      tick();
      chk("unk_valid", {31'd0, de_to_ex_valid}, 32'd1);
      chk("unk_wen", {31'd0, de_wen}, 32'd0);
      chk("unk_aluop", {28'd0, de_aluop}, 32'd0);
      chk("unk_dramen", {31'd0, de_dramen}, 32'd0);

      // SW drives byte enables and rt data
      fetch(itype(6'h2B, 5'd2, 5'd9, 16'hFFFC), 32'h900);
      tick();
      fe_valid = 1'b0;
      tick();
      chk("sw_dramwen", {28'd0, de_dramwen}, 32'hF);
      chk("sw_rtdata", de_rt_data, 32'h1009);
      chk("sw_src2_sext", de_alusrc2, 32'hFFFF_FFFC);

      // Reset while interlocked discards the held instruction
      fetch(rtype(5'd3, 5'd0, 5'd4, 5'd0, 6'h21), 32'hA00);
      tick();
      fe_valid = 1'b0;
      set_fwd(0, 1'b1, 5'd3, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clr_fwd();
      #1;
      chk("rst_stall_allowin", {31'd0, de_allowin}, 32'd1);
      tick();
      chk("rst_stall_valid", {31'd0, de_to_ex_valid}, 32'd0);
      chk("rst_stall_pc", de_pc, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/decode_stage_hs.md
# decode_stage_hs

Parametrised, handshaked successor of the MIPS decode stage. It sits between fetch and execute and owns two registers: the fetch-to-decode latch and the decode-to-execute latch. Flow uses valid/allow-in handshakes, so bubbles replace write-enable masking. The block also provides configurable-depth operand forwarding with load-use interlock and optional branch/jump resolution in decode.

## Interface
- NUM_FWD, 3, number of bypass sources (1..3); index 0 has highest priority (youngest stage).
- BR_IN_DE, 1, 1: resolve BEQ/BNE/J/JAL/JR here and drive br_taken/br_target; 0: br_taken tied 0.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fe_valid  in  1  fetch holds a valid instruction.
- fe_inst  in  32  instruction word.
- fe_pc  in  32  PC of fe_inst.
- de_allowin  out  1  decode accepts fe this cycle.
- flush  in  1  kill both internal latches.
- raddr1, raddr2  out  5  regfile read addresses (rs, rt of latched instruction).
- rdata1, rdata2  in  32  regfile data, combinational.
- fwd_valid, fwd_wen, fwd_is_load  in  NUM_FWD  per-source valid, reg write, data-not-ready flags.
- fwd_dest  in  5*NUM_FWD  destination register per source.
- fwd_data  in  32*NUM_FWD  result per source.
- br_taken  out  1  redirect fetch (one-cycle pulse).
- br_target  out  32  redirect PC.
- ex_allowin  in  1  execute accepts.
- de_to_ex_valid  out  1  output latch valid.
- de_pc, de_alusrc1, de_alusrc2, de_rt_data  out  32  registered operands.
- de_aluop  out  4  alu code: AND 0, OR 1, ADD 2, SUB 3, SLT 4, SLTU 5, SLL 6, SRL 7, SRA 9, LUI 10, XOR 11, NOR 12.
- de_dramen, de_wen, de_is_load  out  1  registered controls.
- de_dramwen  out  4  byte write enables.
- de_regdst  out  5  destination register.

## Operation
- ISA: J, JAL, BEQ, BNE, ADDI(U), SLTI(U), ANDI, ORI, XORI, LUI, LW, SW. R-type: ADD(U), SUB(U), AND, OR, XOR, NOR, SLT(U), SLL, SRL, SRA, SLLV, SRLV, SRAV, JR.
- Unknown encodings: NOP, i.e. wen=0, dramen=0, dramwen=0, aluop=0.
- ds latch: ds_valid, ds_inst, ds_pc load on fe_valid & de_allowin.
- de_allowin = !ds_valid | (ds_ready_go & ex_allowin).
- rs is used unless SLL/SRL/SRA/J/JAL. rt is used for R-type, BEQ, BNE, SW.
- Forwarding per used source: the first index i with fwd_valid[i] & fwd_wen[i] & fwd_dest[i]!=0 & fwd_dest[i]==src wins.
  - If the winner has fwd_is_load[i]=1: ds_ready_go=0 (interlock).
  - Otherwise the operand is fwd_data[i].
  - With no match, the operand is rdata. Register 0 always reads 0.
- Operand selection:
  - alusrc1 = sa zero-extended (SLL/SRL/SRA), ds_pc (JAL), else rs operand.
  - alusrc2 = zero-ext imm (ANDI/ORI/XORI), sign-ext imm (ADDI(U)/SLTI(U)/LW/SW/LUI), rt operand (R-type), 8 (JAL), else 0.
- de_rt_data = rt operand. de_regdst = rd (R-type), rt (I-type writers), 31 (JAL).
- de_dramwen = 4'hF for SW. de_is_load = LW.
- Branch (BR_IN_DE=1):
  - BEQ/BNE compare forwarded operands; target = ds_pc+4+(sext(off)<<2).
  - J/JAL target = {(ds_pc+4)[31:28], index, 2'b00}. JR target = rs operand.
  - br_taken = ds_valid & ds_ready_go & ex_allowin & (taken branch | jump).
  - Delay slot is not cancelled here.
- Output latch, in priority order:
  - reset or flush: de_to_ex_valid <= 0.
  - Else if ex_allowin: de_to_ex_valid <= ds_valid & ds_ready_go, and payload loads when that term is 1.
  - Else: hold.
- flush also clears ds_valid and has priority over fe capture in the same cycle.

## Timing
- Reset: ds_valid=0, de_to_ex_valid=0, every registered output 0. br_taken=0 while ds_valid=0.
- Latency: fe fire at cycle N → ds at N+1 → de_to_ex_valid at N+2 (if no stall). Throughput is 1 instruction/cycle.
- br_taken/br_target are combinational in the decode fire cycle, one cycle wide, never repeated during interlock.
- Load-use: ds holds and emits one bubble per stalled cycle. Release occurs in the cycle fwd_is_load drops.
- ex_allowin=0: both latches hold, de_allowin=0, br_taken=0.
- Reset mid-stall discards the held instruction.

## Test plan
- ADDIU $1,$0,5 then ADDU $2,$1,$1, fwd[0] carries $1=5 → de_alusrc1=de_alusrc2=5, de_regdst=2, aluop=2, no bubble.
- LW $3 in EX (fwd_is_load[0]=1, dest 3), then ADDU $4,$3,$0 → one bubble (de_to_ex_valid=0 one cycle), then alusrc1 = fwd_data from the MEM source.
- BEQ $5,$6,+4 at pc 0x100, equal operands → br_taken=1 single cycle, br_target=0x114. Same with unequal operands → br_taken=0.
- JAL 0x40 at pc 0x10000000 → target 0x10000100, alusrc1=pc, alusrc2=8, regdst=31, wen=1.
- ex_allowin low for 3 cycles with full latches → all outputs stable, de_allowin=0. flush during hold → both valids 0 next cycle.
- Priority: same dest in fwd[0] and fwd[2] → fwd_data[0] selected. Dest 0 → regfile path, value 0.
